// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer and its forwarding matcher.
package store_buffer_pkg;

   localparam int unsigned SB_DEPTH     = 4;
   localparam int unsigned WORD_IDX_LSB = 2;

   // Word-address window decoded by DM; only checked by assertions.
   localparam int unsigned DM_ADDR_HI = 13;
   localparam int unsigned DM_ADDR_LO = 2;

   typedef struct packed {
      logic [29:0] word_addr;
      logic [31:0] data;
      logic [31:0] pc;
   } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding matcher: compares a load word address against every
// valid buffer entry and selects the youngest match relative to tail.
module sb_fwd_match #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [DEPTH-1:0][29:0] entry_addr,
   input  logic [DEPTH-1:0]       entry_valid,
   input  logic [PTR_W-1:0]       tail,
   input  logic [29:0]            ld_word_addr,
   output logic                   hit,
   output logic [PTR_W-1:0]       idx
);

   logic [DEPTH-1:0] match;
   logic [PTR_W-1:0] pos;

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = entry_valid[i] && (entry_addr[i] == ld_word_addr);
      end
   end

   // Walk oldest to youngest so a younger match overrides an older one.
   always_comb begin
      hit = 1'b0;
      idx = tail;
      pos = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         pos = tail - PTR_W'(k);
         if (match[pos]) begin
            hit = 1'b1;
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Word-granular store buffer in front of the single DM port: loads win the port,
// buffered stores drain in order when it is idle, and matching loads are forwarded.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH,
   parameter int unsigned PTR_W = 2
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             St_Valid,
   input  logic [31:0]      St_Addr,
   input  logic [31:0]      St_Data,
   input  logic [31:0]      St_PC,
   output logic             St_Ready,
   input  logic             Ld_Valid,
   input  logic [31:0]      Ld_Addr,
   output logic             Ld_Hit,
   output logic [31:0]      Ld_Data,
   input  logic [31:0]      Mem_ReadData,
   output logic [31:0]      DM_Addr,
   output logic [31:0]      DM_WriteData,
   output logic [31:0]      DM_PC,
   output logic             DM_MemWrite,
   output logic [PTR_W:0]   Count,
   output logic             Empty
);

   sb_entry_t              mem_q [DEPTH];
   logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]         count_q, count_d;
   logic [PTR_W-1:0]       fwd_idx, offset;
   logic                   fwd_hit, ld_miss, push, pop;
   logic [DEPTH-1:0]       entry_valid;
   logic [DEPTH-1:0][29:0] entry_addr;
   logic [WORD_IDX_LSB-1:0] unused_st_lsb;

   assign unused_st_lsb = St_Addr[WORD_IDX_LSB-1:0];

   // Validity is positional relative to head; pointer equality alone is ambiguous.
   always_comb begin
      entry_valid = '0;
      entry_addr  = '0;
      offset      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset         = PTR_W'(i) - head_q;
         entry_valid[i] = {1'b0, offset} < count_q;
         entry_addr[i]  = mem_q[i].word_addr;
      end
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fwd_match (
      .entry_addr   (entry_addr),
      .entry_valid  (entry_valid),
      .tail         (tail_q),
      .ld_word_addr (Ld_Addr[31:WORD_IDX_LSB]),
      .hit          (fwd_hit),
      .idx          (fwd_idx)
   );

   assign Count        = count_q;
   assign Empty        = (count_q == '0);
   assign St_Ready     = (count_q != (PTR_W+1)'(DEPTH));
   assign Ld_Hit       = Ld_Valid && fwd_hit;
   assign ld_miss      = Ld_Valid && !fwd_hit;
   assign DM_MemWrite  = !Empty && !ld_miss;
   assign DM_Addr      = ld_miss ? Ld_Addr : {mem_q[head_q].word_addr, 2'b00};
   assign DM_WriteData = mem_q[head_q].data;
   assign DM_PC        = mem_q[head_q].pc;
   assign Ld_Data      = Ld_Hit ? mem_q[fwd_idx].data : Mem_ReadData;

   assign push = St_Valid && St_Ready;
   assign pop  = DM_MemWrite;

   always_comb begin
      head_d  = pop  ? head_q + PTR_W'(1) : head_q;
      tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         mem_q[tail_q] <= '{word_addr: St_Addr[31:WORD_IDX_LSB], data: St_Data, pc: St_PC};
      end
   end

   a_dm_window: assert property (@(posedge Clk) disable iff (!Reset)
      DM_MemWrite |-> ((DM_Addr[31:DM_ADDR_HI+1] == '0) && (DM_Addr[DM_ADDR_LO-1:0] == '0)));

   a_count_bound: assert property (@(posedge Clk) disable iff (!Reset)
      count_q <= (PTR_W+1)'(DEPTH));

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based model.
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             St_Valid, Ld_Valid;
   logic [31:0]      St_Addr, St_Data, St_PC, Ld_Addr, Mem_ReadData;
   logic             St_Ready, Ld_Hit, DM_MemWrite, Empty;
   logic [31:0]      Ld_Data, DM_Addr, DM_WriteData, DM_PC;
   logic [PTR_W:0]   Count;

   typedef struct {
      logic [29:0] wa;
      logic [31:0] data;
      logic [31:0] pc;
   } ent_t;

   ent_t q[$];
   int   nvec = 0;
   int   nbad = 0;

   always #5 Clk = ~Clk;

   store_buffer #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .St_Valid     (St_Valid),
      .St_Addr      (St_Addr),
      .St_Data      (St_Data),
      .St_PC        (St_PC),
      .St_Ready     (St_Ready),
      .Ld_Valid     (Ld_Valid),
      .Ld_Addr      (Ld_Addr),
      .Ld_Hit       (Ld_Hit),
      .Ld_Data      (Ld_Data),
      .Mem_ReadData (Mem_ReadData),
      .DM_Addr      (DM_Addr),
      .DM_WriteData (DM_WriteData),
      .DM_PC        (DM_PC),
      .DM_MemWrite  (DM_MemWrite),
      .Count        (Count),
      .Empty        (Empty)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, check against the model, then advance the model.
   task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic [31:0] spc, input logic lv, input logic [31:0] la,
                        input logic [31:0] rd);
      logic        hit, miss, wr, ready;
      logic [31:0] fdata;
      ent_t        e;
      @(negedge Clk);
      St_Valid = sv; St_Addr = sa; St_Data = sd; St_PC = spc;
      Ld_Valid = lv; Ld_Addr = la; Mem_ReadData = rd;
      #1;
      hit   = 1'b0;
      fdata = '0;
      if (lv) begin
         foreach (q[i]) begin
            if (q[i].wa == la[31:2]) begin
               hit   = 1'b1;
               fdata = q[i].data;
            end
         end
      end
      miss  = lv && !hit;
      wr    = (q.size() != 0) && !miss;
      ready = q.size() < DEPTH;
      check("count", 32'(Count), 32'(q.size()));
      check("empty", 32'(Empty), 32'(q.size() == 0));
      check("st_ready", 32'(St_Ready), 32'(ready));
      check("ld_hit", 32'(Ld_Hit), 32'(hit));
      check("dm_we", 32'(DM_MemWrite), 32'(wr));
      if (lv) check("ld_data", Ld_Data, hit ? fdata : rd);
      if (miss) check("dm_addr_ld", DM_Addr, la);
      if (wr) begin
         check("dm_addr_st", DM_Addr, {q[0].wa, 2'b00});
         check("dm_wdata", DM_WriteData, q[0].data);
         check("dm_pc", DM_PC, q[0].pc);
         e = q.pop_front();
      end
      if (sv && ready) begin
         e.wa = sa[31:2]; e.data = sd; e.pc = spc;
         q.push_back(e);
      end
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      int st_pct, ld_pct;
      Reset = 1'b0;
      St_Valid = 1'b0; St_Addr = '0; St_Data = '0; St_PC = '0;
      Ld_Valid = 1'b0; Ld_Addr = '0; Mem_ReadData = '0;

      // Reset state
      #2;
      check("rst_empty", 32'(Empty), 32'd1);
      check("rst_ready", 32'(St_Ready), 32'd1);
      check("rst_we", 32'(DM_MemWrite), 32'd0);
      check("rst_count", 32'(Count), 32'd0);
      check("rst_hit", 32'(Ld_Hit), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      idle();
      idle();

      // Single store
      cycle(1'b1, 32'h10, 32'hDEADBEEF, 32'h3000, 1'b0, 32'h0, 32'h0);
      idle();
      check("ss_we", 32'(DM_MemWrite), 32'd1);
      check("ss_addr", DM_Addr, 32'h10);
      check("ss_data", DM_WriteData, 32'hDEADBEEF);
      check("ss_pc", DM_PC, 32'h3000);
      idle();
      check("ss_empty", 32'(Empty), 32'd1);

      // Fill and block behind a load miss
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 32'(i * 4), 32'h100 + 32'(i), 32'h4000 + 32'(i * 4), 1'b1, 32'h100,
               32'hCAFE0000);
      check("fill_count", 32'(Count), 32'd4);
      check("fill_ready", 32'(St_Ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         idle();
         check("drain_order", DM_Addr, 32'(i * 4));
      end
      idle();
      check("drain_empty", 32'(Empty), 32'd1);

      // Forwarding: youngest match wins
      cycle(1'b1, 32'h20, 32'd1, 32'h5000, 1'b1, 32'h100, 32'h11);
      cycle(1'b1, 32'h20, 32'd2, 32'h5004, 1'b1, 32'h100, 32'h12);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h22, 32'h13);
      check("fwd_hit", 32'(Ld_Hit), 32'd1);
      check("fwd_data", Ld_Data, 32'd2);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h24, 32'h5555AAAA);
      check("fwd_miss_hit", 32'(Ld_Hit), 32'd0);
      check("fwd_miss_data", Ld_Data, 32'h5555AAAA);
      check("fwd_miss_addr", DM_Addr, 32'h24);
      idle();
      idle();

      // Simultaneous push and pop across the pointer wrap
      cycle(1'b1, 32'h30, 32'h30, 32'h6000, 1'b1, 32'h100, 32'h0);
      cycle(1'b1, 32'h34, 32'h34, 32'h6004, 1'b1, 32'h100, 32'h0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 32'h40 + 32'(i * 4), 32'h40 + 32'(i), 32'h7000 + 32'(i * 4), 1'b0,
               32'h0, 32'h0);
         check("pp_count", 32'(Count), 32'd2);
      end
      idle();
      idle();
      idle();

      // Randomized traffic in phases of differing store/load pressure
      for (int ph = 0; ph < 6; ph++) begin
         st_pct = 30 + 12 * ph;
         ld_pct = 80 - 12 * ph;
         for (int n = 0; n < 100; n++) begin
            cycle(($urandom_range(0, 99) < st_pct),
                  {22'h0, 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00} >> 2,
                  $urandom, $urandom,
                  ($urandom_range(0, 99) < ld_pct),
                  {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                  $urandom);
         end
      end
      for (int i = 0; i < 6; i++) idle();

      // Reset mid-drain
      cycle(1'b1, 32'h80, 32'hA0, 32'h8000, 1'b1, 32'h100, 32'h0);
      cycle(1'b1, 32'h84, 32'hA1, 32'h8004, 1'b1, 32'h100, 32'h0);
      cycle(1'b1, 32'h88, 32'hA2, 32'h8008, 1'b1, 32'h100, 32'h0);
      @(negedge Clk);
      Reset    = 1'b0;
      St_Valid = 1'b0;
      Ld_Valid = 1'b0;
      #1;
      check("mrst_count_pre", 32'(q.size()), 32'd3);
      check("mrst_empty", 32'(Empty), 32'd1);
      check("mrst_we", 32'(DM_MemWrite), 32'd0);
      check("mrst_count", 32'(Count), 32'd0);
      q.delete();
      for (int i = 0; i < 2; i++) begin
         @(posedge Clk);
         #1;
         check("mrst_hold_we", 32'(DM_MemWrite), 32'd0);
      end
      @(negedge Clk);
      Reset = 1'b1;
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h84, 32'h77);
      check("mrst_ld_hit", 32'(Ld_Hit), 32'd0);
      check("mrst_ld_data", Ld_Data, 32'h77);
      idle();
      check("mrst_no_wr", 32'(DM_MemWrite), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
